mp_reg_file: RTL and testbench



---
 rtl/mp_reg_file_pkg.sv | 28 ++
 rtl/mp_reg_file_wsel.sv | 43 ++++
 rtl/mp_reg_file.sv | 159 +++++++++++++++
 tb/tb_mp_reg_file.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_reg_file_pkg.sv
// Shared types, default sizes and write-port priority helper for mp_reg_file.
package mp_reg_file_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NRD   = 4;
    localparam int DEF_NWR   = 2;

    // Upper bound on write ports supported by the priority helper.
    localparam int MAX_NWR = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Highest-indexed set bit wins; returns 0 when nothing is set.
    function automatic logic [SEL_W-1:0] pick_winner(input logic [MAX_NWR-1:0] hit);
        logic [SEL_W-1:0] win;
        win = '0;
        for (int i = 0; i < MAX_NWR; i++) begin
            win = hit[i] ? SEL_W'(i) : win;
        end
        return win;
    endfunction

endpackage

// File: rtl/mp_reg_file_wsel.sv
// Resolves which write port targets one address: hit, winning data and a
// multi-hit conflict bit. Used per storage entry and per bypassed read port.
module mp_reg_file_wsel
    import mp_reg_file_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = 5,
    parameter int NWR = DEF_NWR
) (
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic [AW-1:0]     tgt_addr,
    output logic              hit,
    output logic              conflict,
    output logic [DW-1:0]     data
);

    logic [MAX_NWR-1:0] hit_vec_s;
    logic [SEL_W-1:0]   sel_s;

    // Per-port address match against this group's target.
    always_comb begin
        hit_vec_s = '0;
        for (int k = 0; k < NWR; k++) begin
            hit_vec_s[k] = wr_en[k] && (wr_addr[k*AW +: AW] == tgt_addr);
        end
    end

    assign sel_s    = pick_winner(hit_vec_s);
    assign hit      = |hit_vec_s;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign conflict = |(hit_vec_s & (hit_vec_s - MAX_NWR'(1)));

    // Data of the winning port.
    always_comb begin
        data = '0;
        for (int k = 0; k < NWR; k++) begin
            data = (int'(sel_s) == k) ? wr_data[k*DW +: DW] : data;
        end
    end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-port register file with write priority, sticky conflict flag and a
// sequenced soft clear. Optional same-cycle bypass: MP_REG_FILE_BYPASS_EN.
module mp_reg_file
    import mp_reg_file_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = DEF_NRD,
    parameter int NWR      = DEF_NWR,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_conflict
);

    // Entry 0 is excluded from writes and conflicts when it is hardwired to zero.
    localparam logic [DEPTH-1:0] ENT_MASK =
        (ZERO_REG != 0) ? {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

    logic [DW-1:0]             mem_r [DEPTH];
    clr_state_t                state_r;
    logic [AW-1:0]             cnt_r;
    logic                      clr_busy_r;
    logic                      clr_done_r;
    logic                      wr_conflict_r;

    logic [DEPTH-1:0]          ent_hit_s;
    logic [DEPTH-1:0]          ent_conf_s;
    logic [DEPTH-1:0]          ent_we_s;
    logic [DEPTH-1:0][DW-1:0]  ent_data_s;
    logic                      any_conf_s;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        mp_reg_file_wsel #(
            .DW  (DW),
            .AW  (AW),
            .NWR (NWR)
        ) u_wsel (
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .tgt_addr (AW'(e)),
            .hit      (ent_hit_s[e]),
            .conflict (ent_conf_s[e]),
            .data     (ent_data_s[e])
        );
    end

    assign ent_we_s   = ent_hit_s & ENT_MASK;
    assign any_conf_s = |(ent_conf_s & ENT_MASK);

    // Storage: clear engine owns the array while CLEAR, otherwise normal writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_r[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (state_r == ST_CLEAR) begin
                    if (cnt_r == AW'(e)) begin
                        mem_r[e] <= '0;
                    end
                end else if (ent_we_s[e]) begin
                    mem_r[e] <= ent_data_s[e];
                end
            end
        end
    end

    // Clear sequencer and sticky conflict flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            clr_busy_r    <= 1'b0;
            clr_done_r    <= 1'b0;
            wr_conflict_r <= 1'b0;
        end else begin
            clr_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wr_conflict_r <= wr_conflict_r | any_conf_s;
                    if (clr_req) begin
                        state_r    <= ST_CLEAR;
                        cnt_r      <= '0;
                        clr_busy_r <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r == AW'(DEPTH-1)) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= '0;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + AW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    clr_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy    = clr_busy_r;
    assign clr_done    = clr_done_r;
    assign wr_conflict = wr_conflict_r;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0] ra_s;
        logic          ra_zero_s;
        logic [DW-1:0] stored_s;

        assign ra_s      = rd_addr[j*AW +: AW];
        assign ra_zero_s = (ZERO_REG != 0) && (ra_s == '0);
        assign stored_s  = ra_zero_s ? '0 : mem_r[ra_s];

`ifdef MP_REG_FILE_BYPASS_EN
        logic          byp_hit_s;
        logic          byp_conf_s;
        logic [DW-1:0] byp_data_s;

        mp_reg_file_wsel #(
            .DW  (DW),
            .AW  (AW),
            .NWR (NWR)
        ) u_byp (
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .tgt_addr (ra_s),
            .hit      (byp_hit_s),
            .conflict (byp_conf_s),
            .data     (byp_data_s)
        );

        // Forward in-flight write data unless the clear engine owns the array.
        assign rd_data[j*DW +: DW] =
            (byp_hit_s && !clr_busy_r && !ra_zero_s) ? byp_data_s : stored_s;
`else
        assign rd_data[j*DW +: DW] = stored_s;
`endif
    end

endmodule

// File: tb/tb_mp_reg_file.sv
// Directed self-checking bench for mp_reg_file (default parameters).
module tb_mp_reg_file;

    logic         clk;
    logic         rst_n;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic         clr_req;
    logic         clr_busy;
    logic         clr_done;
    logic         wr_conflict;

    int tests_run;
    int tests_failed;

    mp_reg_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        rd_addr = {5'd5, 5'd5, 5'd5, 5'd5};
        #3;
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (rd_data[j*32 +: 32] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_rd%0d: got %h expected 00000000", j, rd_data[j*32 +: 32]);
            end
        end
        tests_run++;
        if ({clr_busy, clr_done, wr_conflict} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {clr_busy, clr_done, wr_conflict});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd3};
        wr_data = {32'h12345678, 32'hDEADBEEF};
        @(negedge clk);
        wr_en   = 2'b00;
        rd_addr = {5'd0, 5'd0, 5'd7, 5'd3};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL basic_rd3: got %h expected deadbeef", rd_data[31:0]);
        end
        tests_run++;
        if (rd_data[63:32] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL basic_rd7: got %h expected 12345678", rd_data[63:32]);
        end
        tests_run++;
        if (wr_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_conflict: got %b expected 0", wr_conflict);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en   = 2'b10;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'hFFFFFFFF, 32'h0};
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd0};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_same_cycle: got %h expected 00000000", rd_data[31:0]);
        end
        @(negedge clk);
        wr_en   = 2'b11;
        wr_data = {32'hFFFFFFFF, 32'h55555555};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_after_write: got %h expected 00000000", rd_data[31:0]);
        end
        @(negedge clk);
        wr_en = 2'b00;
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_after_dual: got %h expected 00000000", rd_data[31:0]);
        end
        tests_run++;
        if (wr_conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_conflict: got %b expected 0", wr_conflict);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_en   = 2'b11;
        wr_addr = {5'd9, 5'd9};
        wr_data = {32'h2, 32'h1};
        @(negedge clk);
        wr_en   = 2'b00;
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd9};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'h2) begin
            tests_failed++;
            $display("FAIL collision_winner: got %h expected 00000002", rd_data[31:0]);
        end
        for (int c = 0; c <= 10; c++) begin
            tests_run++;
            if (wr_conflict !== 1'b1) begin
                tests_failed++;
                $display("FAIL collision_sticky_%0d: got %b expected 1", c, wr_conflict);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_cnt;
        int done_n;
        busy_cnt = 0;
        done_cnt = 0;
        done_n   = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en   = 2'b11;
            wr_addr = {5'(2*i+1), 5'(2*i)};
            wr_data = {32'(2*i+2), 32'(2*i+1)};
        end
        @(negedge clk);
        wr_en   = 2'b00;
        rd_addr = {5'd0, 5'd1, 5'd0, 5'd31};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'd32) begin
            tests_failed++;
            $display("FAIL fill_rd31: got %h expected 00000020", rd_data[31:0]);
        end
        tests_run++;
        if (rd_data[95:64] !== 32'd2) begin
            tests_failed++;
            $display("FAIL fill_rd1: got %h expected 00000002", rd_data[95:64]);
        end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            #1;
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_n = n;
            end
            if (n == 10) begin
                wr_en   = 2'b01;
                wr_addr = {5'd0, 5'd4};
                wr_data = {32'h0, 32'h77};
                rd_addr = {5'd20, 5'd0, 5'd0, 5'd0};
                #1;
                tests_run++;
                if (rd_data[127:96] !== 32'd21) begin
                    tests_failed++;
                    $display("FAIL clear_partial_rd20: got %h expected 00000015", rd_data[127:96]);
                end
            end else begin
                wr_en = 2'b00;
            end
            @(negedge clk);
        end
        tests_run++;
        if (busy_cnt !== 32) begin
            tests_failed++;
            $display("FAIL clear_busy_cycles: got %0d expected 32", busy_cnt);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt);
        end
        tests_run++;
        if (done_n !== 33) begin
            tests_failed++;
            $display("FAIL clear_done_timing: got %0d expected 33", done_n);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = {15'd0, 5'(a)};
            #1;
            tests_run++;
            if (rd_data[31:0] !== 32'h0) begin
                tests_failed++;
                $display("FAIL clear_entry_%0d: got %h expected 00000000", a, rd_data[31:0]);
            end
        end
    endtask

    task automatic test_clear_abort();
        int busy_seen;
        int done_seen;
        busy_seen = 0;
        done_seen = 0;
        @(negedge clk);
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd20};
        wr_data = {32'h0, 32'h20};
        @(negedge clk);
        wr_en   = 2'b00;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({clr_busy, clr_done, wr_conflict} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_flags: got %b expected 000", {clr_busy, clr_done, wr_conflict});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (clr_busy) busy_seen++;
            if (clr_done) done_seen++;
            @(negedge clk);
        end
        tests_run++;
        if (done_seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d expected 0", done_seen);
        end
        tests_run++;
        if (busy_seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_busy: got %0d expected 0", busy_seen);
        end
        rd_addr = {15'd0, 5'd20};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_entry20: got %h expected 00000000", rd_data[31:0]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        logic [31:0] exp_pri;
`ifdef MP_REG_FILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
        exp_pri  = 32'h2;
`else
        exp_same = 32'h11;
        exp_pri  = 32'h0;
`endif
        @(negedge clk);
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd12};
        wr_data = {32'h0, 32'h11};
        @(negedge clk);
        wr_data = {32'h0, 32'hA5A5A5A5};
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd12};
        #1;
        tests_run++;
        if (rd_data[31:0] !== exp_same) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: got %h expected %h", rd_data[31:0], exp_same);
        end
        @(negedge clk);
        wr_en   = 2'b11;
        wr_addr = {5'd13, 5'd13};
        wr_data = {32'h2, 32'h1};
        rd_addr = {5'd0, 5'd0, 5'd13, 5'd12};
        #1;
        tests_run++;
        if (rd_data[31:0] !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL bypass_next_cycle: got %h expected a5a5a5a5", rd_data[31:0]);
        end
        tests_run++;
        if (rd_data[63:32] !== exp_pri) begin
            tests_failed++;
            $display("FAIL bypass_priority: got %h expected %h", rd_data[63:32], exp_pri);
        end
        @(negedge clk);
        wr_en = 2'b00;
        #1;
        tests_run++;
        if (rd_data[63:32] !== 32'h2) begin
            tests_failed++;
            $display("FAIL bypass_pri_stored: got %h expected 00000002", rd_data[63:32]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_collision();
        test_clear();
        test_clear_abort();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
